// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write buffer between the MEM-stage control and Data_Memory.
//   Stores are queued in FIFO order and drained one word at a time. Each
//   drain holds dm_write_o for WRITE_CYCLES cycles. Loads are forwarded
//   from the youngest matching entry, and go to memory on a miss.
//
// Ports
//   clk_i, rst_i        clock; asynchronous active-high reset
//   mem_write_i         store request (wins when mem_read_i is also high)
//   mem_read_i          load request
//   addr_i, data_i      word address / store data
//   data_o              load data, combinational, same cycle as mem_read_i
//   stall_o             store not accepted this cycle; hold the MEM stage
//   count_o             number of valid entries
//   dm_addr_o/dm_data_o Data_Memory address / write data
//   dm_write_o          Data_Memory MemWrite
//   dm_read_o           Data_Memory MemRead
//   dm_data_i           Data_Memory read data
//   dbg_state_o         drain FSM state (0 = IDLE, 1 = WRITE)
//
// Handshake: a store is a valid/ready transfer with valid = mem_write_i and
// ready = !stall_o. It completes on the rising edge where both are high.
// A stalled store must be held stable until it completes. Loads never stall.
module store_buffer #(
  parameter int DEPTH        = 4,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_write_i,
  input  logic                     mem_read_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              data_i,
  output logic [31:0]              data_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              dm_addr_o,
  output logic [31:0]              dm_data_o,
  output logic                     dm_write_o,
  output logic                     dm_read_o,
  input  logic [31:0]              dm_data_i,
  output logic                     dbg_state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WRITE_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];

  logic            hit, coal;
  logic [PW-1:0]   hit_idx, coal_idx;
  logic            load_act, load_miss, pop, push, full;

  // Walk entries oldest to youngest so the last match is the youngest.
  // The head that is currently being written is excluded from coalescing:
  // its data may already be partly in memory, so a newer store to the same
  // address becomes a separate entry that drains after it.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    hit_idx  = '0;
    coal     = 1'b0;
    coal_idx = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (((PW+1)'(k) < count_q) && (addr_q[idx] == addr_i)) begin
        hit     = 1'b1;
        hit_idx = idx;
        if (!((k == 0) && (state_q == WRITE))) begin
          coal     = 1'b1;
          coal_idx = idx;
        end
      end
    end
  end

  assign load_act  = mem_read_i && !mem_write_i;
  assign load_miss = load_act && !hit;
  assign full      = (count_q == (PW+1)'(DEPTH));
  // A load miss takes the memory port, so the head write cannot complete.
  assign pop       = (state_q == WRITE) && (wcnt_q == CW'(1)) && !load_miss;
  // A pop frees a slot on the same edge, so a full buffer can still accept.
  assign push      = mem_write_i && !coal && (!full || pop);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) || push) begin
          state_d = WRITE;
          wcnt_d  = CW'(WRITE_CYCLES);
        end
      end
      WRITE: begin
        if (load_miss) begin
          wcnt_d = CW'(WRITE_CYCLES);
        end else if (pop) begin
          if (count_d != '0) wcnt_d = CW'(WRITE_CYCLES);
          else               state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: validity is defined by head/count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= data_i;
    end else if (mem_write_i && coal) begin
      data_q[coal_idx] <= data_i;
    end
  end

  // Outputs are forced low during reset, including the input-driven load path.
  always_comb begin
    data_o     = '0;
    stall_o    = 1'b0;
    dm_addr_o  = '0;
    dm_data_o  = '0;
    dm_write_o = 1'b0;
    dm_read_o  = 1'b0;
    if (!rst_i) begin
      stall_o = mem_write_i && !coal && full && !pop;
      if (load_miss) begin
        dm_read_o = 1'b1;
        dm_addr_o = addr_i;
        data_o    = dm_data_i;
      end else begin
        if (load_act) data_o = data_q[hit_idx];
        if (state_q == WRITE) begin
          dm_write_o = 1'b1;
          dm_addr_o  = addr_q[head_q];
          dm_data_o  = data_q[head_q];
        end
      end
    end
  end

  assign count_o     = count_q;
  assign dbg_state_o = state_q;

endmodule
